inst_buffer: RTL and testbench
==============================

Name: inst_buffer

Overview:
- Circular instruction queue between fetch/branch predictor and decode/dispatch.
- Accepts up to N fetched instructions per cycle; holds them in program order.
- Presents the oldest N to the decoder and reports how many are valid; dispatch drives that count as inst_buffer_instructions_valid.
- Retires entries by dispatch's num_dispatched; flushed wholesale on branch-stack restore.

Parameters:
N, 3, superscalar width (lanes per cycle in and out)
DEPTH, 8, number of entries; power of two, DEPTH >= N
PTR_BITS, $clog2(DEPTH), head/tail pointer width
CNT_BITS, $clog2(DEPTH+1), occupancy counter width
NUM_SCALAR_BITS, $clog2(N+1), width of per-cycle lane counts

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
fetch_valid  in  N  per-lane valid from fetch; lane 0 oldest
fetch_inst  in  N*32  instruction words
fetch_PC  in  N*32  instruction PCs
fetch_NPC  in  N*32  predicted next PCs
ib_spots  out  NUM_SCALAR_BITS  free entries offered to fetch, min(DEPTH-count, N)
num_accepted  out  NUM_SCALAR_BITS  fetch lanes written this cycle
inst_buffer_instructions_valid  out  NUM_SCALAR_BITS  min(count, N)
ib_inst  out  N*32  lane i = entry (head+i) mod DEPTH
ib_PC  out  N*32  as above
ib_NPC  out  N*32  as above
num_dispatched  in  NUM_SCALAR_BITS  entries consumed by dispatch this cycle
flush  in  1  branch-stack restore (restore_valid); empties buffer

Behaviour:
- State:
  - head and tail: PTR_BITS each.
  - count: CNT_BITS, range 0..DEPTH.
  - Entry array: inst, PC, NPC.
- Reset, synchronous:
  - head = tail = count = 0.
  - Entry array need not be cleared.
  - While count = 0: ib_spots = N, inst_buffer_instructions_valid = 0, num_accepted = 0, all ib_* lanes = 0.
- All outputs are combinational from registered state and the current inputs.
  - There is no same-cycle write-to-read bypass: an entry written in cycle t is first visible on ib_* in cycle t+1.
- ib_spots uses the registered count only. This cycle's pops do not enlarge it, so there is no combinational path from num_dispatched to fetch.
- Push (leading-run rule):
  - k = number of consecutive 1s in fetch_valid starting at lane 0. Lanes after the first 0 are ignored.
  - num_accepted = min(k, ib_spots), or 0 when flush or reset is asserted.
  - Lanes 0..num_accepted-1 are written to (tail+i) mod DEPTH.
  - tail advances by num_accepted mod DEPTH.
  - Unaccepted lanes are dropped; fetch must re-present them.
- Pop:
  - p = min(num_dispatched, inst_buffer_instructions_valid). An over-request is clamped and never underflows.
  - head advances by p mod DEPTH.
- count_next = count + num_accepted - p. Push and pop in the same cycle are both applied.
- Output lanes:
  - Lane i < inst_buffer_instructions_valid carries entry (head+i) mod DEPTH.
  - Lanes at or above that count drive 0.
- Wrap-around: all pointer arithmetic is modulo DEPTH; program order is preserved across the wrap.
- Full (count = DEPTH): ib_spots = 0 and no push occurs. Entries popped in that cycle free space starting the next cycle.
- Empty (count = 0): inst_buffer_instructions_valid = 0, so dispatch pops nothing.
- Flush:
  - Next cycle: head = tail = count = 0.
  - The same-cycle push and pop are discarded.
  - Priority order: reset > flush > normal push/pop.
- Reset or flush mid-stream: occupied entries are silently discarded; no partial state survives.

Test Plan:
- Reset, then idle -> ib_spots=3, inst_buffer_instructions_valid=0, num_accepted=0, ib_PC all 0.
- Push fetch_valid=3'b111 with PCs 0x0/0x4/0x8 -> num_accepted=3 that cycle.
  - Next cycle: valid=3, ib_PC lane0=0x0, lane2=0x8.
  - Then num_dispatched=2 -> next cycle valid=1, lane0 PC=0x8, ib_spots=3.
- Push 3, 3, 2 with no pops -> count=8, ib_spots=0.
  - Next fetch_valid=3'b111 gives num_accepted=0.
  - num_dispatched=3 -> ib_spots=3 the following cycle, not the same cycle.
- With count=6, push 3'b111 -> num_accepted=2.
  - Wrap test: head=6, tail wraps past 7 -> 0; pushing PCs 0x100/0x104/0x108 at entries 6,7,0 emerges in order on lanes 0..2.
- Push fetch_valid=3'b101 with ib_spots=3 -> num_accepted=1; only lane 0 stored.
  - num_dispatched=3 while count=1 -> clamped pop of 1, count=0.
- count=5, same cycle flush=1, push 3, pop 1 -> num_accepted=0.
  - Next cycle: count=0, valid=0, ib_spots=3, head=tail=0.
  - A flush asserted together with reset behaves as reset.

Source files
------------

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and decode/dispatch.
// Accepts the leading run of valid fetch lanes, presents the oldest N entries, and retires by dispatch count.
module inst_buffer #(
  parameter int N               = 3,
  parameter int DEPTH           = 8,
  parameter int PTR_BITS        = $clog2(DEPTH),
  parameter int CNT_BITS        = $clog2(DEPTH + 1),
  parameter int NUM_SCALAR_BITS = $clog2(N + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N-1:0]               fetch_valid,
  input  logic [N*32-1:0]            fetch_inst,
  input  logic [N*32-1:0]            fetch_PC,
  input  logic [N*32-1:0]            fetch_NPC,
  output logic [NUM_SCALAR_BITS-1:0] ib_spots,
  output logic [NUM_SCALAR_BITS-1:0] num_accepted,
  output logic [NUM_SCALAR_BITS-1:0] inst_buffer_instructions_valid,
  output logic [N*32-1:0]            ib_inst,
  output logic [N*32-1:0]            ib_PC,
  output logic [N*32-1:0]            ib_NPC,
  input  logic [NUM_SCALAR_BITS-1:0] num_dispatched,
  input  logic                       flush
);

  logic [PTR_BITS-1:0] head, tail;
  logic [CNT_BITS-1:0] count;
  logic [31:0]         mem_inst [DEPTH];
  logic [31:0]         mem_pc   [DEPTH];
  logic [31:0]         mem_npc  [DEPTH];

  logic [CNT_BITS-1:0]        free;
  logic [NUM_SCALAR_BITS-1:0] spots;
  logic [NUM_SCALAR_BITS-1:0] avail;
  logic [NUM_SCALAR_BITS-1:0] run_len;
  logic [NUM_SCALAR_BITS-1:0] accepted;
  logic [NUM_SCALAR_BITS-1:0] popped;
  logic                       in_run;
  logic [PTR_BITS-1:0]        rd_idx;

  // spots depends on registered count only, keeping num_dispatched off the fetch path
  always_comb begin
    free     = CNT_BITS'(DEPTH) - count;
    spots    = (free >= CNT_BITS'(N)) ? NUM_SCALAR_BITS'(N) : NUM_SCALAR_BITS'(free);
    avail    = (count >= CNT_BITS'(N)) ? NUM_SCALAR_BITS'(N) : NUM_SCALAR_BITS'(count);
    run_len  = '0;
    in_run   = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_run && fetch_valid[i]) run_len = run_len + NUM_SCALAR_BITS'(1);
      else                          in_run  = 1'b0;
    end
    if (reset || flush) accepted = '0;
    else                accepted = (run_len < spots) ? run_len : spots;
    popped = (num_dispatched < avail) ? num_dispatched : avail;
  end

  always_comb begin
    ib_inst = '0;
    ib_PC   = '0;
    ib_NPC  = '0;
    rd_idx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rd_idx = head + PTR_BITS'(i);
      if (NUM_SCALAR_BITS'(i) < avail) begin
        ib_inst[i*32 +: 32] = mem_inst[rd_idx];
        ib_PC[i*32 +: 32]   = mem_pc[rd_idx];
        ib_NPC[i*32 +: 32]  = mem_npc[rd_idx];
      end
    end
  end

  assign ib_spots                       = spots;
  assign num_accepted                   = accepted;
  assign inst_buffer_instructions_valid = avail;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PTR_BITS'(accepted);
      head  <= head + PTR_BITS'(popped);
      count <= count + CNT_BITS'(accepted) - CNT_BITS'(popped);
    end
  end

  // Storage has no reset; accepted is already forced to zero under reset/flush
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (NUM_SCALAR_BITS'(i) < accepted) begin
        mem_inst[tail + PTR_BITS'(i)] <= fetch_inst[i*32 +: 32];
        mem_pc[tail + PTR_BITS'(i)]   <= fetch_PC[i*32 +: 32];
        mem_npc[tail + PTR_BITS'(i)]  <= fetch_NPC[i*32 +: 32];
      end
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (N=3, DEPTH=8).
module tb_inst_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  fetch_valid;
  logic [95:0] fetch_inst, fetch_PC, fetch_NPC;
  logic [1:0]  ib_spots, num_accepted, inst_buffer_instructions_valid;
  logic [95:0] ib_inst, ib_PC, ib_NPC;
  logic [1:0]  num_dispatched;
  logic        flush;

  int checks = 0;
  int errors = 0;

  inst_buffer #(.N(3), .DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_PC(fetch_PC), .fetch_NPC(fetch_NPC),
    .ib_spots(ib_spots), .num_accepted(num_accepted),
    .inst_buffer_instructions_valid(inst_buffer_instructions_valid),
    .ib_inst(ib_inst), .ib_PC(ib_PC), .ib_NPC(ib_NPC),
    .num_dispatched(num_dispatched), .flush(flush)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk_inst(input logic [31:0] p);
    return p ^ 32'hDEAD_0000;
  endfunction

  task automatic drive(input logic [2:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] p2, input logic [1:0] nd, input logic fl);
    fetch_valid    = v;
    fetch_PC       = {p2, p1, p0};
    fetch_inst     = {mk_inst(p2), mk_inst(p1), mk_inst(p0)};
    fetch_NPC      = {p2 + 32'd4, p1 + 32'd4, p0 + 32'd4};
    num_dispatched = nd;
    flush          = fl;
  endtask

  task automatic idle();
    drive(3'b000, 0, 0, 0, 2'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear();
    drive(3'b000, 0, 0, 0, 2'd0, 1'b1);
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    drive(3'b111, 32'h50, 32'h54, 32'h58, 2'd0, 1'b0);
    #1;
    checks++;
    if (num_accepted !== 2'd0) begin
      errors++; $display("FAIL reset_accept: got %0d expected 0", num_accepted);
    end
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (ib_spots !== 2'd3) begin
      errors++; $display("FAIL reset_spots: got %0d expected 3", ib_spots);
    end
    checks++;
    if (inst_buffer_instructions_valid !== 2'd0) begin
      errors++; $display("FAIL reset_valid: got %0d expected 0", inst_buffer_instructions_valid);
    end
    checks++;
    if (num_accepted !== 2'd0) begin
      errors++; $display("FAIL reset_idle_accept: got %0d expected 0", num_accepted);
    end
    checks++;
    if (ib_PC !== 96'd0 || ib_inst !== 96'd0 || ib_NPC !== 96'd0) begin
      errors++; $display("FAIL reset_lanes: got pc %h inst %h expected 0", ib_PC, ib_inst);
    end
  endtask

  task automatic test_basic();
    clear();
    drive(3'b111, 32'h0, 32'h4, 32'h8, 2'd0, 1'b0);
    #1;
    checks++;
    if (num_accepted !== 2'd3) begin
      errors++; $display("FAIL basic_accept: got %0d expected 3", num_accepted);
    end
    checks++;
    if (inst_buffer_instructions_valid !== 2'd0) begin
      errors++; $display("FAIL basic_no_bypass: got %0d expected 0", inst_buffer_instructions_valid);
    end
    tick();
    idle();
    #1;
    checks++;
    if (inst_buffer_instructions_valid !== 2'd3) begin
      errors++; $display("FAIL basic_valid: got %0d expected 3", inst_buffer_instructions_valid);
    end
    checks++;
    if (ib_PC !== {32'h8, 32'h4, 32'h0}) begin
      errors++; $display("FAIL basic_pc: got %h expected %h", ib_PC, {32'h8, 32'h4, 32'h0});
    end
    checks++;
    if (ib_inst[63:32] !== 32'hDEAD_0004 || ib_NPC[95:64] !== 32'hC) begin
      errors++; $display("FAIL basic_inst_npc: got %h/%h expected DEAD0004/0000000c", ib_inst[63:32], ib_NPC[95:64]);
    end
    drive(3'b000, 0, 0, 0, 2'd2, 1'b0);
    tick();
    idle();
    #1;
    checks++;
    if (inst_buffer_instructions_valid !== 2'd1 || ib_PC !== {32'h0, 32'h0, 32'h8}) begin
      errors++; $display("FAIL basic_pop2: got valid %0d pc %h expected 1 / 8", inst_buffer_instructions_valid, ib_PC);
    end
    checks++;
    if (ib_spots !== 2'd3) begin
      errors++; $display("FAIL basic_spots: got %0d expected 3", ib_spots);
    end
  endtask

  task automatic test_full();
    clear();
    drive(3'b111, 32'h10, 32'h14, 32'h18, 2'd0, 1'b0);
    tick();
    drive(3'b111, 32'h1C, 32'h20, 32'h24, 2'd0, 1'b0);
    tick();
    drive(3'b111, 32'h28, 32'h2C, 32'h30, 2'd0, 1'b0);
    #1;
    checks++;
    if (ib_spots !== 2'd2 || num_accepted !== 2'd2) begin
      errors++; $display("FAIL full_count6: got spots %0d acc %0d expected 2/2", ib_spots, num_accepted);
    end
    tick();
    drive(3'b111, 32'h40, 32'h44, 32'h48, 2'd3, 1'b0);
    #1;
    checks++;
    if (ib_spots !== 2'd0 || num_accepted !== 2'd0) begin
      errors++; $display("FAIL full_block: got spots %0d acc %0d expected 0/0", ib_spots, num_accepted);
    end
    checks++;
    if (ib_PC !== {32'h18, 32'h14, 32'h10}) begin
      errors++; $display("FAIL full_lanes: got %h expected %h", ib_PC, {32'h18, 32'h14, 32'h10});
    end
    tick();
    idle();
    #1;
    checks++;
    if (ib_spots !== 2'd3 || ib_PC !== {32'h24, 32'h20, 32'h1C}) begin
      errors++; $display("FAIL full_after_pop: got spots %0d pc %h expected 3 / 24201c", ib_spots, ib_PC);
    end
  endtask

  task automatic test_wrap();
    clear();
    drive(3'b111, 32'h60, 32'h64, 32'h68, 2'd0, 1'b0);
    tick();
    drive(3'b111, 32'h6C, 32'h70, 32'h74, 2'd3, 1'b0);
    tick();
    drive(3'b000, 0, 0, 0, 2'd3, 1'b0);
    tick();
    drive(3'b111, 32'h100, 32'h104, 32'h108, 2'd0, 1'b0);
    #1;
    checks++;
    if (num_accepted !== 2'd3 || inst_buffer_instructions_valid !== 2'd0) begin
      errors++; $display("FAIL wrap_push: got acc %0d valid %0d expected 3/0", num_accepted, inst_buffer_instructions_valid);
    end
    tick();
    drive(3'b001, 32'h10C, 32'h0, 32'h0, 2'd3, 1'b0);
    #1;
    checks++;
    if (ib_PC !== {32'h108, 32'h104, 32'h100} || ib_NPC !== {32'h10C, 32'h108, 32'h104}) begin
      errors++; $display("FAIL wrap_order: got pc %h npc %h expected 108/104/100", ib_PC, ib_NPC);
    end
    tick();
    idle();
    #1;
    checks++;
    if (inst_buffer_instructions_valid !== 2'd1 || ib_PC !== {32'h0, 32'h0, 32'h10C}) begin
      errors++; $display("FAIL wrap_pushpop: got valid %0d pc %h expected 1 / 10c", inst_buffer_instructions_valid, ib_PC);
    end
  endtask

  task automatic test_partial();
    clear();
    drive(3'b110, 32'h1F0, 32'h1F4, 32'h1F8, 2'd0, 1'b0);
    #1;
    checks++;
    if (num_accepted !== 2'd0) begin
      errors++; $display("FAIL partial_lane0_off: got %0d expected 0", num_accepted);
    end
    drive(3'b101, 32'h200, 32'h204, 32'h208, 2'd0, 1'b0);
    #1;
    checks++;
    if (num_accepted !== 2'd1) begin
      errors++; $display("FAIL partial_accept: got %0d expected 1", num_accepted);
    end
    tick();
    drive(3'b000, 0, 0, 0, 2'd3, 1'b0);
    #1;
    checks++;
    if (inst_buffer_instructions_valid !== 2'd1 || ib_PC !== {32'h0, 32'h0, 32'h200}) begin
      errors++; $display("FAIL partial_stored: got valid %0d pc %h expected 1 / 200", inst_buffer_instructions_valid, ib_PC);
    end
    tick();
    idle();
    #1;
    checks++;
    if (inst_buffer_instructions_valid !== 2'd0 || ib_spots !== 2'd3 || ib_PC !== 96'd0) begin
      errors++; $display("FAIL partial_clamp: got valid %0d spots %0d pc %h expected 0/3/0", inst_buffer_instructions_valid, ib_spots, ib_PC);
    end
  endtask

  task automatic test_flush();
    clear();
    drive(3'b111, 32'h300, 32'h304, 32'h308, 2'd0, 1'b0);
    tick();
    drive(3'b011, 32'h30C, 32'h310, 32'h314, 2'd0, 1'b0);
    tick();
    drive(3'b111, 32'h320, 32'h324, 32'h328, 2'd1, 1'b1);
    #1;
    checks++;
    if (num_accepted !== 2'd0) begin
      errors++; $display("FAIL flush_accept: got %0d expected 0", num_accepted);
    end
    tick();
    idle();
    #1;
    checks++;
    if (inst_buffer_instructions_valid !== 2'd0 || ib_spots !== 2'd3 || ib_PC !== 96'd0) begin
      errors++; $display("FAIL flush_empty: got valid %0d spots %0d pc %h expected 0/3/0", inst_buffer_instructions_valid, ib_spots, ib_PC);
    end
    drive(3'b111, 32'h400, 32'h404, 32'h408, 2'd0, 1'b0);
    tick();
    idle();
    #1;
    checks++;
    if (inst_buffer_instructions_valid !== 2'd3 || ib_PC !== {32'h408, 32'h404, 32'h400}) begin
      errors++; $display("FAIL flush_refill: got valid %0d pc %h expected 3 / 408404400", inst_buffer_instructions_valid, ib_PC);
    end
    reset = 1'b1;
    drive(3'b111, 32'h500, 32'h504, 32'h508, 2'd0, 1'b1);
    #1;
    checks++;
    if (num_accepted !== 2'd0) begin
      errors++; $display("FAIL flush_reset_accept: got %0d expected 0", num_accepted);
    end
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (inst_buffer_instructions_valid !== 2'd0 || ib_spots !== 2'd3) begin
      errors++; $display("FAIL flush_reset_state: got valid %0d spots %0d expected 0/3", inst_buffer_instructions_valid, ib_spots);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    logic [31:0] exp_pc;
    clear();
    drive(3'b111, 32'h600, 32'h604, 32'h608, 2'd0, 1'b0);
    tick();
    for (int j = 1; j <= 4; j++) begin
      base   = 32'h600 + 32'(12 * j);
      exp_pc = 32'h600 + 32'(12 * (j - 1));
      drive(3'b111, base, base + 32'd4, base + 32'd8, 2'd3, 1'b0);
      #1;
      checks++;
      if (num_accepted !== 2'd3 || ib_PC[31:0] !== exp_pc) begin
        errors++; $display("FAIL b2b_step%0d: got acc %0d pc0 %h expected 3 / %h", j, num_accepted, ib_PC[31:0], exp_pc);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (inst_buffer_instructions_valid !== 2'd3 || ib_PC[95:64] !== 32'h638) begin
      errors++; $display("FAIL b2b_tail: got valid %0d pc2 %h expected 3 / 638", inst_buffer_instructions_valid, ib_PC[95:64]);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_partial();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
